// File: rtl/date_rewind_seq.sv
// date_rewind_seq
//   Sequential day-of-month rewinder. Given a starting day and a count N,
//   steps backwards one day per clock inside a fixed-length month and
//   reports the resulting day plus how many times the walk wrapped from
//   day 1 back to day MONTH_DAYS.
//
// Parameters
//   MONTH_DAYS : days per month (28..31); valid days are 1..MONTH_DAYS
//
// Ports
//   clk     : rising-edge clock
//   rst     : synchronous, active-high reset
//   start   : request strobe, only accepted while busy is low
//   datein  : starting day (1..MONTH_DAYS)
//   N       : number of days to rewind (0..63)
//   busy    : high while stepping
//   done    : one-cycle pulse, dateout/borrow valid
//   dateout : resulting day, held until the next done
//   borrow  : number of month wraps taken (0..3)
//   err     : range-error flag
//
// Optional feature macro
//   DATE_RANGE_CHECK_EN : when defined, an out-of-range datein on an accepted
//   start completes immediately with dateout=0, borrow=0 and err=1. When not
//   defined, err is tied low and out-of-range inputs are not checked.

module date_rewind_seq #(
  parameter int MONTH_DAYS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] datein,
  input  logic [5:0] N,
  output logic       busy,
  output logic       done,
  output logic [4:0] dateout,
  output logic [1:0] borrow,
  output logic       err
);

  localparam logic [4:0] MD = 5'(MONTH_DAYS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [4:0] work_date, work_n;
  logic [5:0] cnt, cnt_n;
  logic [1:0] wraps, wraps_n;
  logic [4:0] dateout_n;
  logic [1:0] borrow_n;
  logic       err_n;
  logic [4:0] step_date;
  logic [1:0] step_wraps;
  logic       range_bad;

  // Out-of-range detection only exists when the check is built in; otherwise
  // it is a constant zero and the accept path degenerates to the plain load.
`ifdef DATE_RANGE_CHECK_EN
  assign range_bad = (datein == 5'd0) || (datein > MD);
`else
  assign range_bad = 1'b0;
`endif

  // State register plus all datapath registers; everything is computed in
  // the combinational block below so this block only captures or resets.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      work_date <= 5'd0;
      cnt       <= 6'd0;
      wraps     <= 2'd0;
      dateout   <= 5'd0;
      borrow    <= 2'd0;
    end else begin
      state     <= state_n;
      work_date <= work_n;
      cnt       <= cnt_n;
      wraps     <= wraps_n;
      dateout   <= dateout_n;
      borrow    <= borrow_n;
    end
  end

`ifdef DATE_RANGE_CHECK_EN
  logic err_q;

  // err is sticky: it only changes on an accepted start or on reset.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_n;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // One backwards step: day 1 rolls over to the last day of the month and
  // counts as a wrap. borrow cannot exceed 3 because N is at most 63.
  always_comb begin
    step_date  = (work_date == 5'd1) ? MD : (work_date - 5'd1);
    step_wraps = (work_date == 5'd1) ? (wraps + 2'd1) : wraps;
  end

  // Next-state and datapath update. IDLE and DONE share the accept logic so
  // a start in the DONE cycle chains directly into the next job.
  always_comb begin
    state_n   = state;
    work_n    = work_date;
    cnt_n     = cnt;
    wraps_n   = wraps;
    dateout_n = dateout;
    borrow_n  = borrow;
`ifdef DATE_RANGE_CHECK_EN
    err_n     = err_q;
`else
    err_n     = 1'b0;
`endif

    case (state)
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (start) begin
          work_n  = datein;
          cnt_n   = N;
          wraps_n = 2'd0;
          err_n   = range_bad;
          if (range_bad) begin
            state_n   = S_DONE;
            dateout_n = 5'd0;
            borrow_n  = 2'd0;
          end else if (N == 6'd0) begin
            state_n   = S_DONE;
            dateout_n = datein;
            borrow_n  = 2'd0;
          end else begin
            state_n = S_RUN;
          end
        end
      end

      S_RUN: begin
        work_n  = step_date;
        wraps_n = step_wraps;
        cnt_n   = cnt - 6'd1;
        // Last step: publish the post-step values directly.
        if (cnt == 6'd1) begin
          state_n   = S_DONE;
          dateout_n = step_date;
          borrow_n  = step_wraps;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_date_rewind_seq.sv
// tb_date_rewind_seq
//   Directed bench for date_rewind_seq with MONTH_DAYS=30. Inputs are driven
//   on the falling edge and outputs are sampled on the falling edge.
//   Define DATE_RANGE_CHECK_EN for both bench and design to cover the
//   range-error path.

module tb_date_rewind_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] datein;
  logic [5:0] N;
  logic       busy;
  logic       done;
  logic [4:0] dateout;
  logic [1:0] borrow;
  logic       err;

  int compared;
  int mismatched;
  int cycles;
  int busyCycles;
  int doneSeen;

  date_rewind_seq #(.MONTH_DAYS(30)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .datein  (datein),
    .N       (N),
    .busy    (busy),
    .done    (done),
    .dateout (dateout),
    .borrow  (borrow),
    .err     (err)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Issue a one-cycle start from a falling edge; returns on the falling edge
  // right after the start was sampled.
  task automatic applyStimulus(input logic [4:0] d, input logic [5:0] n);
    start  = 1'b1;
    datein = d;
    N      = n;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Wait for done, counting cycles since the start edge (the caller is already
  // startCount cycles in). Bounded so a stuck design still reaches the summary.
  task automatic waitDone(input int startCount, output int count, output int busyCount);
    count     = startCount;
    busyCount = 0;
    while (!done && count < 200) begin
      if (busy) busyCount++;
      @(negedge clk);
      count++;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst    = 1'b1;
    start  = 1'b0;
    datein = 5'd1;
    N      = 6'd0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_dateout", dateout, 0);
    checkOutput("rst_borrow", borrow, 0);
    checkOutput("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // 25 back 15 -> 10, no wrap, 16 cycles, busy for 15
    applyStimulus(5'd25, 6'd15);
    waitDone(1, cycles, busyCycles);
    checkOutput("j1_done", done, 1);
    checkOutput("j1_latency", cycles, 16);
    checkOutput("j1_busy_cycles", busyCycles, 15);
    checkOutput("j1_dateout", dateout, 10);
    checkOutput("j1_borrow", borrow, 0);
    checkOutput("j1_err", err, 0);
    @(negedge clk);
    checkOutput("j1_done_pulse", done, 0);
    checkOutput("j1_hold", dateout, 10);

    // 1 back 15 -> 16, one wrap
    applyStimulus(5'd1, 6'd15);
    waitDone(1, cycles, busyCycles);
    checkOutput("j2_dateout", dateout, 16);
    checkOutput("j2_borrow", borrow, 1);
    @(negedge clk);

    // 30 back 63 -> 27, two wraps, 64 cycles
    applyStimulus(5'd30, 6'd63);
    waitDone(1, cycles, busyCycles);
    checkOutput("j3_latency", cycles, 64);
    checkOutput("j3_dateout", dateout, 27);
    checkOutput("j3_borrow", borrow, 2);
    @(negedge clk);

    // 1 back 63 -> 28, three wraps (borrow maximum)
    applyStimulus(5'd1, 6'd63);
    waitDone(1, cycles, busyCycles);
    checkOutput("j4_dateout", dateout, 28);
    checkOutput("j4_borrow", borrow, 3);
    @(negedge clk);

    // N=0: done next cycle, busy never seen
    applyStimulus(5'd15, 6'd0);
    waitDone(1, cycles, busyCycles);
    checkOutput("j5_latency", cycles, 1);
    checkOutput("j5_busy_cycles", busyCycles, 0);
    checkOutput("j5_dateout", dateout, 15);
    checkOutput("j5_borrow", borrow, 0);
    @(negedge clk);

    // 28 back 10 with a start pulsed mid-run that must be ignored
    applyStimulus(5'd28, 6'd10);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(5'd5, 6'd1);
    waitDone(4, cycles, busyCycles);
    checkOutput("j6_latency", cycles, 11);
    checkOutput("j6_dateout", dateout, 18);
    checkOutput("j6_borrow", borrow, 0);

    // Back-to-back start in the done cycle: 5 back 1 -> 4 two cycles later
    applyStimulus(5'd5, 6'd1);
    checkOutput("j7_busy", busy, 1);
    checkOutput("j7_held", dateout, 18);
    waitDone(1, cycles, busyCycles);
    checkOutput("j7_latency", cycles, 2);
    checkOutput("j7_dateout", dateout, 4);
    @(negedge clk);

    // Reset mid-run aborts the job without a done pulse
    applyStimulus(5'd20, 6'd40);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("r_busy", busy, 0);
    checkOutput("r_done", done, 0);
    checkOutput("r_dateout", dateout, 0);
    checkOutput("r_borrow", borrow, 0);
    doneSeen = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("r_no_done", doneSeen, 0);

    // Job after reset: 3 back 5 -> 28, one wrap
    applyStimulus(5'd3, 6'd5);
    waitDone(1, cycles, busyCycles);
    checkOutput("r2_latency", cycles, 6);
    checkOutput("r2_dateout", dateout, 28);
    checkOutput("r2_borrow", borrow, 1);
    @(negedge clk);

`ifdef DATE_RANGE_CHECK_EN
    // Out-of-range day completes immediately with err set
    applyStimulus(5'd0, 6'd5);
    waitDone(1, cycles, busyCycles);
    checkOutput("e1_latency", cycles, 1);
    checkOutput("e1_err", err, 1);
    checkOutput("e1_dateout", dateout, 0);
    checkOutput("e1_borrow", borrow, 0);
    @(negedge clk);
    checkOutput("e1_err_hold", err, 1);

    // Next valid start clears err
    applyStimulus(5'd29, 6'd1);
    waitDone(1, cycles, busyCycles);
    checkOutput("e2_err", err, 0);
    checkOutput("e2_dateout", dateout, 28);
    @(negedge clk);
`else
    checkOutput("err_tied", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
